// File: rtl/seq_debug_cmd_initiator_if.sv
// Client command/response handshake and Avalon-MM master bus for the sequencer debug mailbox
// initiator. The master modport is the initiator; the slave modport is the client plus the bus slave.
interface seq_debug_cmd_initiator_if #(
    parameter int unsigned NUM_PARAMS = 4
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [31:0]               cmd_code;
    logic [3:0]                cmd_nparams;
    logic [32*NUM_PARAMS-1:0]  cmd_params;
    logic                      rsp_valid;
    logic [1:0]                rsp_status;
    logic                      rsp_timeout;
    logic [31:0]               avm_address;
    logic                      avm_write;
    logic                      avm_read;
    logic [31:0]               avm_writedata;
    logic [31:0]               avm_readdata;
    logic                      avm_waitrequest;

    modport master (
        input  cmd_valid, cmd_code, cmd_nparams, cmd_params, avm_readdata, avm_waitrequest,
        output cmd_ready, rsp_valid, rsp_status, rsp_timeout,
               avm_address, avm_write, avm_read, avm_writedata
    );

    modport slave (
        output cmd_valid, cmd_code, cmd_nparams, cmd_params, avm_readdata, avm_waitrequest,
        input  cmd_ready, rsp_valid, rsp_status, rsp_timeout,
               avm_address, avm_write, avm_read, avm_writedata
    );
endinterface

// File: rtl/seq_debug_cmd_initiator.sv
// Host-side initiator for the sequencer debug command mailbox: writes params and opcode,
// polls CMD_STATUS, retires the mailbox with a zero write, then reports the result.
module seq_debug_cmd_initiator #(
    parameter logic [31:0] DEBUG_BASE    = 32'h0001_5238,
    parameter int unsigned NUM_PARAMS    = 4,
    parameter int unsigned POLL_INTERVAL = 16,
    parameter int unsigned TIMEOUT_POLLS = 1024
) (
    input  logic                        avl_clk,
    input  logic                        avl_reset,
    seq_debug_cmd_initiator_if.master   bus
);
    localparam int unsigned PCW = $clog2(TIMEOUT_POLLS + 1);
    localparam int unsigned WCW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [PCW-1:0] POLL_LIMIT = PCW'(TIMEOUT_POLLS);
    localparam logic [WCW-1:0] WAIT_LAST  = WCW'(POLL_INTERVAL - 1);
    localparam logic [3:0]     NP_MAX     = 4'(NUM_PARAMS);
    localparam logic [31:0]    ADDR_REQ   = DEBUG_BASE + 32'h0000_0008;
    localparam logic [31:0]    ADDR_STAT  = DEBUG_BASE + 32'h0000_000C;
    localparam logic [31:0]    ADDR_PARAM = DEBUG_BASE + 32'h0000_0010;

    typedef enum logic [3:0] {
        ST_IDLE, ST_WR_PARAM, ST_WR_CMD, ST_POLL_WAIT, ST_POLL_RD,
        ST_CLR_CMD, ST_CLR_WAIT, ST_CLR_RD, ST_RESP
    } state_t;

    state_t                    state_r, state_s;
    logic                      cmd_ready_r, cmd_ready_s;
    logic                      rsp_valid_r, rsp_valid_s;
    logic [1:0]                status_r, status_s;
    logic                      timeout_r, timeout_s;
    logic [31:0]               avm_address_r, avm_address_s;
    logic                      avm_write_r, avm_write_s;
    logic                      avm_read_r, avm_read_s;
    logic [31:0]               avm_writedata_r, avm_writedata_s;
    logic [31:0]               code_r, code_s;
    logic [3:0]                nparams_r, nparams_s;
    logic [32*NUM_PARAMS-1:0]  params_r, params_s;
    logic [3:0]                idx_r, idx_s;
    logic [PCW-1:0]            poll_cnt_r, poll_cnt_s;
    logic [WCW-1:0]            wait_cnt_r, wait_cnt_s;

    logic                      accept_s;
    logic [3:0]                nparams_clamp_s;
    logic [31:0]               param_sel_s;
    logic [PCW-1:0]            poll_inc_s;

    assign accept_s        = (avm_write_r | avm_read_r) & ~bus.avm_waitrequest;
    assign nparams_clamp_s = (bus.cmd_nparams > NP_MAX) ? NP_MAX : bus.cmd_nparams;
    assign param_sel_s     = params_r[32*int'(idx_r) +: 32];
    assign poll_inc_s      = (poll_cnt_r == POLL_LIMIT) ? poll_cnt_r : poll_cnt_r + PCW'(1);

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge avl_clk or posedge avl_reset) begin
        if (avl_reset) begin
            state_r         <= ST_IDLE;
            cmd_ready_r     <= 1'b1;
            rsp_valid_r     <= 1'b0;
            status_r        <= 2'd0;
            timeout_r       <= 1'b0;
            avm_address_r   <= 32'd0;
            avm_write_r     <= 1'b0;
            avm_read_r      <= 1'b0;
            avm_writedata_r <= 32'd0;
            code_r          <= 32'd0;
            nparams_r       <= 4'd0;
            params_r        <= '0;
            idx_r           <= 4'd0;
            poll_cnt_r      <= '0;
            wait_cnt_r      <= '0;
        end else begin
            state_r         <= state_s;
            cmd_ready_r     <= cmd_ready_s;
            rsp_valid_r     <= rsp_valid_s;
            status_r        <= status_s;
            timeout_r       <= timeout_s;
            avm_address_r   <= avm_address_s;
            avm_write_r     <= avm_write_s;
            avm_read_r      <= avm_read_s;
            avm_writedata_r <= avm_writedata_s;
            code_r          <= code_s;
            nparams_r       <= nparams_s;
            params_r        <= params_s;
            idx_r           <= idx_s;
            poll_cnt_r      <= poll_cnt_s;
            wait_cnt_r      <= wait_cnt_s;
        end
    end

    // Next-state logic. Each bus state raises its strobe from a low-strobe cycle and drops it
    // on acceptance, which yields the idle cycle between consecutive transfers.
    always_comb begin
        state_s         = state_r;
        cmd_ready_s     = cmd_ready_r;
        rsp_valid_s     = 1'b0;
        status_s        = status_r;
        timeout_s       = timeout_r;
        avm_address_s   = avm_address_r;
        avm_write_s     = avm_write_r;
        avm_read_s      = avm_read_r;
        avm_writedata_s = avm_writedata_r;
        code_s          = code_r;
        nparams_s       = nparams_r;
        params_s        = params_r;
        idx_s           = idx_r;
        poll_cnt_s      = poll_cnt_r;
        wait_cnt_s      = wait_cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_r) begin
                    code_s      = bus.cmd_code;
                    nparams_s   = nparams_clamp_s;
                    params_s    = bus.cmd_params;
                    cmd_ready_s = 1'b0;
                    status_s    = 2'd0;
                    timeout_s   = 1'b0;
                    idx_s       = 4'd0;
                    state_s     = (nparams_clamp_s != 4'd0) ? ST_WR_PARAM : ST_WR_CMD;
                end else begin
                    cmd_ready_s = 1'b1;
                end
            end
            ST_WR_PARAM: begin
                if (!avm_write_r) begin
                    avm_write_s     = 1'b1;
                    avm_address_s   = ADDR_PARAM + {26'd0, idx_r, 2'b00};
                    avm_writedata_s = param_sel_s;
                end else if (accept_s) begin
                    avm_write_s = 1'b0;
                    if (idx_r + 4'd1 == nparams_r) begin
                        idx_s   = 4'd0;
                        state_s = ST_WR_CMD;
                    end else begin
                        idx_s   = idx_r + 4'd1;
                    end
                end else begin
                    state_s = ST_WR_PARAM;
                end
            end
            ST_WR_CMD, ST_CLR_CMD: begin
                if (!avm_write_r) begin
                    avm_write_s     = 1'b1;
                    avm_address_s   = ADDR_REQ;
                    avm_writedata_s = (state_r == ST_WR_CMD) ? code_r : 32'd0;
                end else if (accept_s) begin
                    avm_write_s = 1'b0;
                    poll_cnt_s  = '0;
                    wait_cnt_s  = '0;
                    state_s     = (state_r == ST_WR_CMD) ? ST_POLL_WAIT : ST_CLR_WAIT;
                end else begin
                    state_s = state_r;
                end
            end
            ST_POLL_WAIT, ST_CLR_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    wait_cnt_s = '0;
                    state_s    = (state_r == ST_POLL_WAIT) ? ST_POLL_RD : ST_CLR_RD;
                end else begin
                    wait_cnt_s = wait_cnt_r + WCW'(1);
                end
            end
            ST_POLL_RD: begin
                if (!avm_read_r) begin
                    avm_read_s    = 1'b1;
                    avm_address_s = ADDR_STAT;
                end else if (accept_s) begin
                    avm_read_s = 1'b0;
                    status_s   = bus.avm_readdata[1:0];
                    poll_cnt_s = poll_inc_s;
                    if (bus.avm_readdata[1]) begin
                        state_s = ST_CLR_CMD;
                    end else if (poll_inc_s == POLL_LIMIT) begin
                        timeout_s = 1'b1;
                        state_s   = ST_CLR_CMD;
                    end else begin
                        state_s = ST_POLL_WAIT;
                    end
                end else begin
                    state_s = ST_POLL_RD;
                end
            end
            ST_CLR_RD: begin
                // Clear-phase reads only gate the exit; the reported status stays the poll result.
                if (!avm_read_r) begin
                    avm_read_s    = 1'b1;
                    avm_address_s = ADDR_STAT;
                end else if (accept_s) begin
                    avm_read_s = 1'b0;
                    poll_cnt_s = poll_inc_s;
                    if (bus.avm_readdata[1:0] == 2'd0) begin
                        rsp_valid_s = 1'b1;
                        state_s     = ST_RESP;
                    end else if (poll_inc_s == POLL_LIMIT) begin
                        timeout_s   = 1'b1;
                        rsp_valid_s = 1'b1;
                        state_s     = ST_RESP;
                    end else begin
                        state_s = ST_CLR_WAIT;
                    end
                end else begin
                    state_s = ST_CLR_RD;
                end
            end
            ST_RESP: begin
                cmd_ready_s = 1'b1;
                state_s     = ST_IDLE;
            end
            default: begin
                avm_write_s = 1'b0;
                avm_read_s  = 1'b0;
                cmd_ready_s = 1'b1;
                state_s     = ST_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready     = cmd_ready_r;
    assign bus.rsp_valid     = rsp_valid_r;
    assign bus.rsp_status    = status_r;
    assign bus.rsp_timeout   = timeout_r;
    assign bus.avm_address   = avm_address_r;
    assign bus.avm_write     = avm_write_r;
    assign bus.avm_read      = avm_read_r;
    assign bus.avm_writedata = avm_writedata_r;
endmodule

// File: tb/tb_seq_debug_cmd_initiator.sv
// Directed bench for seq_debug_cmd_initiator against a scripted mailbox slave model.
module tb_seq_debug_cmd_initiator;
    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic avl_clk = 1'b0;
    logic avl_reset;
    always #5 avl_clk = ~avl_clk;

    seq_debug_cmd_initiator_if #(.NUM_PARAMS(4)) bus ();

    seq_debug_cmd_initiator #(
        .DEBUG_BASE(32'h0001_5238), .NUM_PARAMS(4), .POLL_INTERVAL(3), .TIMEOUT_POLLS(4)
    ) dut (
        .avl_clk(avl_clk), .avl_reset(avl_reset), .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // slave script
    int          busy_polls   = 0;
    logic [1:0]  final_status = 2'd2;
    logic        clr_stuck    = 1'b0;
    int          stall_cycles = 0;

    logic [31:0] mb_cmd     = 32'd0;
    int          poll_reads = 0;
    int          stall_cnt  = 0;
    logic [1:0]  slave_status;
    xfer_t       log_q[$];
    xfer_t       exp_q[$];

    wire stb = bus.avm_read | bus.avm_write;

    always_comb begin
        slave_status = 2'd0;
        if (mb_cmd != 32'd0) slave_status = (poll_reads < busy_polls) ? 2'd1 : final_status;
        else                 slave_status = clr_stuck ? 2'd1 : 2'd0;
    end

    assign bus.avm_waitrequest = stb && (stall_cnt < stall_cycles);
    assign bus.avm_readdata    = 32'hABCD_0000 | {30'd0, slave_status};

    // mailbox slave: stall, log, update
    always @(posedge avl_clk or posedge avl_reset) begin
        if (avl_reset) begin
            stall_cnt <= 0;
        end else if (stb) begin
            if (bus.avm_waitrequest) begin
                stall_cnt <= stall_cnt + 1;
            end else begin
                stall_cnt <= 0;
                if (bus.avm_write) begin
                    log_q.push_back({1'b1, bus.avm_address, bus.avm_writedata});
                    if (bus.avm_address == 32'h0001_5240) begin
                        mb_cmd     <= bus.avm_writedata;
                        poll_reads <= 0;
                    end
                end else begin
                    log_q.push_back({1'b0, bus.avm_address, 32'd0});
                    poll_reads <= poll_reads + 1;
                end
            end
        end
    end

    // protocol monitor
    int cyc = 0;
    int overlap_cnt = 0, gap_cnt = 0, unstable_cnt = 0, stall_seen = 0;
    int acc_cyc[$], rsp_cyc[$];
    logic        prev_acc = 1'b0, prev_stall = 1'b0, prev_rd = 1'b0;
    logic [31:0] prev_addr = 32'd0, prev_data = 32'd0;

    always @(posedge avl_clk) cyc <= cyc + 1;

    always @(negedge avl_clk) begin
        if (avl_reset) begin
            prev_acc   <= 1'b0;
            prev_stall <= 1'b0;
        end else begin
            if (bus.avm_read && bus.avm_write) overlap_cnt <= overlap_cnt + 1;
            if (prev_acc && stb) gap_cnt <= gap_cnt + 1;
            if (prev_stall && (!stb || bus.avm_address != prev_addr ||
                               bus.avm_writedata != prev_data || bus.avm_read != prev_rd))
                unstable_cnt <= unstable_cnt + 1;
            if (stb && bus.avm_waitrequest) stall_seen <= stall_seen + 1;
            prev_acc   <= stb && !bus.avm_waitrequest;
            prev_stall <= stb && bus.avm_waitrequest;
            prev_addr  <= bus.avm_address;
            prev_data  <= bus.avm_writedata;
            prev_rd    <= bus.avm_read;
            if (bus.rsp_valid) rsp_cyc.push_back(cyc);
            if (bus.cmd_valid && bus.cmd_ready) acc_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ctl"}, {bus.cmd_ready, bus.rsp_valid, bus.rsp_status, bus.rsp_timeout,
                                 bus.avm_read, bus.avm_write}, 96'b1000000);
        check_eq({tag, "_addr"}, bus.avm_address, 96'd0);
        check_eq({tag, "_wdata"}, bus.avm_writedata, 96'd0);
    endtask

    task automatic exp_w(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({1'b1, a, d});
    endtask

    task automatic exp_r(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, a, 32'd0});
    endtask

    task automatic set_slave(input int busy, input logic [1:0] fin, input logic stuck);
        busy_polls   = busy;
        final_status = fin;
        clr_stuck    = stuck;
    endtask

    task automatic send_cmd(input logic [31:0] code, input logic [3:0] n, input logic [127:0] p);
        @(negedge avl_clk);
        bus.cmd_code    = code;
        bus.cmd_nparams = n;
        bus.cmd_params  = p;
        bus.cmd_valid   = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (bus.cmd_ready) break;
            @(negedge avl_clk);
        end
        @(posedge avl_clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [1:0] st, input logic to);
        logic got = 1'b0;
        logic [2:0] seen = 3'd0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge avl_clk);
            if (bus.rsp_valid) begin
                got  = 1'b1;
                seen = {bus.rsp_status, bus.rsp_timeout};
                break;
            end
        end
        check_eq({tag, "_rsp_seen"}, got, 96'd1);
        if (got) begin
            check_eq({tag, "_status_timeout"}, seen, {st, to});
            @(negedge avl_clk);
            check_eq({tag, "_pulse_then_ready"}, {bus.rsp_valid, bus.cmd_ready}, 96'b01);
        end
    endtask

    task automatic check_log(input string tag, input int start);
        @(negedge avl_clk);
        check_eq({tag, "_nxfers"}, log_q.size() - start, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (start + i < log_q.size())
                check_eq($sformatf("%s_xfer%0d", tag, i), log_q[start + i], exp_q[i]);
        end
    endtask

    localparam logic [31:0] PA = 32'hAAAA_0001, PB = 32'hBBBB_0002;
    localparam logic [31:0] PC = 32'hCCCC_0003, PD = 32'hDDDD_0004;

    task automatic build_t1_exp();
        exp_q = {};
        exp_w(32'h0001_5248, PA);
        exp_w(32'h0001_524C, PB);
        exp_w(32'h0001_5240, 32'd5);
        exp_r(32'h0001_5244, 4);
        exp_w(32'h0001_5240, 32'd0);
        exp_r(32'h0001_5244, 1);
    endtask

    initial begin
        int start, s0, a0, r0, nrsp;
        avl_reset       = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_code    = 32'd0;
        bus.cmd_nparams = 4'd0;
        bus.cmd_params  = 128'd0;
        repeat (3) @(negedge avl_clk);
        check_reset_outputs("reset");
        avl_reset = 1'b0;
        repeat (2) @(negedge avl_clk);

        // T1: two params, BUSY x3 then DONE (4th read lands exactly on the poll limit)
        set_slave(3, 2'd2, 1'b0);
        start = log_q.size();
        send_cmd(32'd5, 4'd2, {PD, PC, PB, PA});
        wait_rsp("t1", 2'd2, 1'b0);
        build_t1_exp();
        check_log("t1", start);

        // T2: no params, ERROR on first read
        set_slave(0, 2'd3, 1'b0);
        start = log_q.size();
        send_cmd(32'd7, 4'd0, {PD, PC, PB, PA});
        wait_rsp("t2", 2'd3, 1'b0);
        exp_q = {};
        exp_w(32'h0001_5240, 32'd7);
        exp_r(32'h0001_5244, 1);
        exp_w(32'h0001_5240, 32'd0);
        exp_r(32'h0001_5244, 1);
        check_log("t2", start);

        // T3: BUSY forever, both phases time out; nparams 15 clamps to 4
        set_slave(100000, 2'd2, 1'b1);
        start = log_q.size();
        send_cmd(32'd9, 4'd15, {PD, PC, PB, PA});
        wait_rsp("t3", 2'd1, 1'b1);
        exp_q = {};
        exp_w(32'h0001_5248, PA);
        exp_w(32'h0001_524C, PB);
        exp_w(32'h0001_5250, PC);
        exp_w(32'h0001_5254, PD);
        exp_w(32'h0001_5240, 32'd9);
        exp_r(32'h0001_5244, 4);
        exp_w(32'h0001_5240, 32'd0);
        exp_r(32'h0001_5244, 4);
        check_log("t3", start);

        // T4: T1 with 7 waitrequest cycles on every transfer
        set_slave(3, 2'd2, 1'b0);
        stall_cycles = 7;
        s0 = stall_seen;
        start = log_q.size();
        send_cmd(32'd5, 4'd2, {PD, PC, PB, PA});
        wait_rsp("t4", 2'd2, 1'b0);
        build_t1_exp();
        check_log("t4", start);
        check_eq("t4_stall_cycles", 96'(stall_seen - s0), 96'd63);
        stall_cycles = 0;

        // T5: reset during POLL_WAIT, then a fresh command
        start = log_q.size();
        send_cmd(32'd5, 4'd2, {PD, PC, PB, PA});
        for (int k = 0; k < 200; k++) begin
            if (log_q.size() >= start + 3) break;
            @(negedge avl_clk);
        end
        check_eq("t5_reached_poll_wait", log_q.size() - start, 96'd3);
        avl_reset = 1'b1;
        #1 check_reset_outputs("t5_in_reset");
        @(negedge avl_clk);
        avl_reset = 1'b0;
        @(negedge avl_clk);
        start = log_q.size();
        send_cmd(32'd6, 4'd1, {PD, PC, PB, PC});
        wait_rsp("t5b", 2'd2, 1'b0);
        exp_q = {};
        exp_w(32'h0001_5248, PC);
        exp_w(32'h0001_5240, 32'd6);
        exp_r(32'h0001_5244, 4);
        exp_w(32'h0001_5240, 32'd0);
        exp_r(32'h0001_5244, 1);
        check_log("t5b", start);

        // T6: cmd_valid held high across two commands
        set_slave(0, 2'd2, 1'b0);
        a0 = acc_cyc.size();
        r0 = rsp_cyc.size();
        nrsp = 0;
        @(negedge avl_clk);
        bus.cmd_code    = 32'd3;
        bus.cmd_nparams = 4'd0;
        bus.cmd_valid   = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge avl_clk);
            if (bus.rsp_valid) begin
                nrsp++;
                if (nrsp == 2) begin
                    bus.cmd_valid = 1'b0;
                    break;
                end
            end
        end
        repeat (3) @(negedge avl_clk);
        check_eq("t6_accepts", acc_cyc.size() - a0, 96'd2);
        check_eq("t6_responses", rsp_cyc.size() - r0, 96'd2);
        if (acc_cyc.size() - a0 == 2 && rsp_cyc.size() - r0 >= 1)
            check_eq("t6_second_accept_cycle", acc_cyc[a0 + 1], rsp_cyc[r0] + 1);

        check_eq("no_strobe_overlap", overlap_cnt, 96'd0);
        check_eq("idle_gap_between_xfers", gap_cnt, 96'd0);
        check_eq("stable_while_stalled", unstable_cnt, 96'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
